// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: pipeline bundles, FSM states, funct3 codes and dbus structs.
// MEM_MISALIGN_CHECK_EN adds the misalign flag to memory_data_t.
package mem_access_stage_pkg;

    localparam int XLEN        = 64;
    localparam int ALIGN_BYTES = 8;
    localparam int OFFSET_W    = $clog2(ALIGN_BYTES);

    typedef logic [XLEN-1:0]        word_t;
    typedef logic [4:0]             creg_addr_t;
    typedef logic [31:0]            instr_t;
    typedef logic [ALIGN_BYTES-1:0] strobe_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        HOLD = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef struct packed {
        word_t      pc;
        instr_t     raw_instr;
        word_t      aluout;
        word_t      writedata;
        creg_addr_t dst;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
    } execute_data_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memtoreg;
        creg_addr_t dst;
        word_t      pc;
        instr_t     raw_instr;
        word_t      aluout;
        word_t      memdata;
`ifdef MEM_MISALIGN_CHECK_EN
        logic       misalign;
`endif
    } memory_data_t;

    typedef struct packed {
        logic    valid;
        word_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    // Byte-lane mask of an access of the given size, before shifting to its offset.
    function automatic strobe_t size_mask(input msize_t size);
        unique case (size)
            MSIZE1:  return strobe_t'(8'h01);
            MSIZE2:  return strobe_t'(8'h03);
            MSIZE4:  return strobe_t'(8'h0F);
            default: return strobe_t'(8'hFF);
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [OFFSET_W-1:0] offset, input msize_t size);
        logic [OFFSET_W-1:0] low_mask;
        unique case (size)
            MSIZE1:  low_mask = 3'b000;
            MSIZE2:  low_mask = 3'b001;
            MSIZE4:  low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
        return (offset & low_mask) != '0;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load-data alignment and sign/zero extension: shifts the addressed bytes down
// and extends them according to funct3. Purely combinational.
module load_extend
    import mem_access_stage_pkg::*;
(
    input  word_t               data_i,
    input  logic [OFFSET_W-1:0] offset_i,
    input  logic [2:0]          funct3_i,
    output word_t               ext_o
);

    word_t shifted;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        shifted = data_i >> {offset_i, 3'b000};
        ext_o   = shifted;
        unique case (funct3_i)
            F3_LB:   ext_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            F3_LH:   ext_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   ext_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_LBU:  ext_o = {{(XLEN-8){1'b0}},         shifted[7:0]};
            F3_LHU:  ext_o = {{(XLEN-16){1'b0}},        shifted[15:0]};
            F3_LWU:  ext_o = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: ext_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on dbus, stalls until data_ok, forwards load data.
// Optional MEM_MISALIGN_CHECK_EN: misaligned accesses skip the bus and retire flagged after one cycle.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    input  execute_data_t in_data,
    output logic          in_ready,
    output logic          out_valid,
    output memory_data_t  out_data,
    input  logic          out_ready,
    input  logic          flush,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output word_t         memdata_fwd
);

    mem_state_t    state_q, state_d;
    execute_data_t ex_q, ex_d;
    memory_data_t  out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic          flushed_q, flushed_d;

    logic                accept;
    logic                in_is_mem;
    logic                go_bus;
    logic [OFFSET_W-1:0] offset;
    msize_t              size;
    word_t               load_ext;
    logic                unused_addr_ok;

    function automatic memory_data_t build_result(input execute_data_t ex, input word_t memdata);
        memory_data_t r;
        r           = '0;
        r.valid     = 1'b1;
        r.regwrite  = ex.regwrite & ~ex.memwrite;
        r.memtoreg  = ex.memtoreg;
        r.dst       = ex.dst;
        r.pc        = ex.pc;
        r.raw_instr = ex.raw_instr;
        r.aluout    = ex.aluout;
        r.memdata   = memdata;
        return r;
    endfunction

    assign offset         = ex_q.aluout[OFFSET_W-1:0];
    assign size           = msize_t'(ex_q.raw_instr[13:12]);
    assign in_is_mem      = in_data.memread | in_data.memwrite;
    assign in_ready       = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept         = in_valid && in_ready && !flush;
    assign unused_addr_ok = dresp.addr_ok;

`ifdef MEM_MISALIGN_CHECK_EN
    assign go_bus = in_is_mem &&
                    !is_misaligned(in_data.aluout[OFFSET_W-1:0], msize_t'(in_data.raw_instr[13:12]));
`else
    assign go_bus = in_is_mem;
`endif

    load_extend u_load_extend (
        .data_i   (dresp.data),
        .offset_i (offset),
        .funct3_i (ex_q.raw_instr[14:12]),
        .ext_o    (load_ext)
    );

    always_comb begin
        state_d     = state_q;
        ex_d        = ex_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        flushed_d   = flushed_q;

        unique case (state_q)
            IDLE: begin
                if (out_ready || flush) out_valid_d = 1'b0;
                if (accept) begin
                    if (go_bus) begin
                        ex_d      = in_data;
                        flushed_d = 1'b0;
                        state_d   = BUS;
                    end else begin
                        out_d       = build_result(in_data, '0);
`ifdef MEM_MISALIGN_CHECK_EN
                        out_d.misalign = in_is_mem;
                        if (in_is_mem) out_d.regwrite = 1'b0;
`endif
                        out_valid_d = 1'b1;
                    end
                end
            end
            BUS: begin
                // The bus cannot be cancelled: a flush only marks the result for discard.
                if (dresp.data_ok) begin
                    flushed_d = 1'b0;
                    if (flushed_q || flush) begin
                        state_d = IDLE;
                    end else begin
                        out_d       = build_result(ex_q, ex_q.memread ? load_ext : '0);
                        out_valid_d = 1'b1;
                        state_d     = out_ready ? IDLE : HOLD;
                    end
                end else if (flush) begin
                    flushed_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready || flush) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dreq       = '0;
        dreq.valid = (state_q == BUS);
        dreq.addr  = ex_q.aluout;
        dreq.size  = size;
        if (ex_q.memwrite) begin
            dreq.strobe = size_mask(size) << offset;
            dreq.data   = ex_q.writedata << {offset, 3'b000};
        end
    end

    always_comb begin
        out_data       = out_q;
        out_data.valid = out_valid_q;
    end

    assign out_valid   = out_valid_q;
    assign memdata_fwd = out_q.memdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ex_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            flushed_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= state_d;
            ex_q        <= ex_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            flushed_q   <= flushed_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: ALU pass-through, store lanes, load extension,
// HOLD back-pressure, flush during a bus access and asynchronous reset mid-access.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    execute_data_t in_data;
    logic          in_ready;
    logic          out_valid;
    memory_data_t  out_data;
    logic          out_ready;
    logic          flush;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    word_t         memdata_fwd;

    int n_vectors     = 0;
    int n_miscompares = 0;

    mem_access_stage dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush       (flush),
        .dreq        (dreq),
        .dresp       (dresp),
        .memdata_fwd (memdata_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic execute_data_t mk(input word_t aluout, input word_t wdata, input logic rd,
                                         input logic wr, input logic [2:0] f3, input logic [4:0] dst);
        execute_data_t e;
        e           = '0;
        e.pc        = 64'h8000_1000;
        e.raw_instr = {17'd0, f3, 12'h003};
        e.aluout    = aluout;
        e.writedata = wdata;
        e.dst       = dst;
        e.memread   = rd;
        e.memwrite  = wr;
        e.memtoreg  = rd;
        e.regwrite  = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input word_t addr, input logic [2:0] f3,
                           input word_t bus, input word_t exp);
        in_valid = 1'b1;
        in_data  = mk(addr, '0, 1'b1, 1'b0, f3, 5'd7);
        tick();
        in_valid = 1'b0;
        check({tag, "_req"}, 64'(dreq.valid), 64'd1);
        dresp.data_ok = 1'b1;
        dresp.data    = bus;
        tick();
        dresp = '0;
        check({tag, "_vld"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, out_data.memdata, exp);
        check({tag, "_fwd"}, memdata_fwd, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        flush     = 1'b0;
        dresp     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dreq_valid", 64'(dreq.valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data_zero", 64'(out_data == '0), 64'd1);
        check("rst_fwd", memdata_fwd, 64'd0);
        resetn = 1'b1;

        // Non-memory instructions back to back
        in_valid = 1'b1;
        in_data  = mk(64'h10, '0, 1'b0, 1'b0, 3'b000, 5'd5);
        #1;
        check("alu_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("alu_out_valid", 64'(out_valid), 64'd1);
        check("alu_aluout", out_data.aluout, 64'h10);
        check("alu_memdata", out_data.memdata, 64'd0);
        check("alu_regwrite", 64'(out_data.regwrite), 64'd1);
        check("alu_no_req", 64'(dreq.valid), 64'd0);
        in_data = mk(64'h20, '0, 1'b0, 1'b0, 3'b000, 5'd6);
        check("alu_b2b_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("alu_b2b_valid", 64'(out_valid), 64'd1);
        check("alu_b2b_aluout", out_data.aluout, 64'h20);
        check("alu_b2b_dst", 64'(out_data.dst), 64'd6);
        tick();
        check("alu_drain", 64'(out_valid), 64'd0);

        // SW at offset 4, held three cycles before data_ok
        in_valid = 1'b1;
        in_data  = mk(64'h8000_0004, 64'hDEAD_BEEF, 1'b0, 1'b1, F3_SW, 5'd3);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("sw_req_valid", 64'(dreq.valid), 64'd1);
            check("sw_addr", dreq.addr, 64'h8000_0004);
            check("sw_size", 64'(dreq.size), 64'd2);
            check("sw_strobe", 64'(dreq.strobe), 64'hF0);
            check("sw_data", dreq.data, 64'hDEAD_BEEF_0000_0000);
            check("sw_in_ready", 64'(in_ready), 64'd0);
            if (c == 2) dresp.data_ok = 1'b1;
            tick();
        end
        dresp = '0;
        check("sw_out_valid", 64'(out_valid), 64'd1);
        check("sw_no_regwrite", 64'(out_data.regwrite), 64'd0);
        check("sw_req_done", 64'(dreq.valid), 64'd0);

        // Loads: data_ok in the same cycle as the request
        do_load("lb",  64'h1003, F3_LB,  64'h1122_3344_80FF_EE00, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 64'h1003, F3_LBU, 64'h1122_3344_80FF_EE00, 64'h0000_0000_0000_0080);
        do_load("lh",  64'h1002, F3_LH,  64'h1122_3344_80FF_EE00, 64'hFFFF_FFFF_FFFF_80FF);
        do_load("lwu", 64'h1004, F3_LWU, 64'h1122_3344_80FF_EE00, 64'h0000_0000_1122_3344);
        do_load("lw",  64'h1000, F3_LW,  64'h1122_3344_80FF_EE00, 64'hFFFF_FFFF_80FF_EE00);

        // LD with back-pressure into HOLD
        in_valid = 1'b1;
        in_data  = mk(64'h2000, '0, 1'b1, 1'b0, F3_LD, 5'd9);
        tick();
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hCAFE_BABE_1234_5678;
        check("ld_req", 64'(dreq.valid), 64'd1);
        tick();
        dresp = '0;
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_in_ready", 64'(in_ready), 64'd0);
        check("hold_no_req", 64'(dreq.valid), 64'd0);
        check("hold_data", out_data.memdata, 64'hCAFE_BABE_1234_5678);
        tick();
        check("hold_valid2", 64'(out_valid), 64'd1);
        check("hold_in_ready2", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("hold_ready_ignored", 64'(in_ready), 64'd0);
        tick();
        check("rel_valid", 64'(out_valid), 64'd0);
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Flush while in IDLE drops the accept
        in_valid = 1'b1;
        flush    = 1'b1;
        in_data  = mk(64'h44, '0, 1'b0, 1'b0, 3'b000, 5'd4);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_valid", 64'(out_valid), 64'd0);

        // Flush during BUS, data_ok two cycles later
        in_valid = 1'b1;
        in_data  = mk(64'h3000, '0, 1'b1, 1'b0, F3_LW, 5'd8);
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        check("fl_req0", 64'(dreq.valid), 64'd1);
        tick();
        flush = 1'b0;
        check("fl_req1", 64'(dreq.valid), 64'd1);
        check("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("fl_req2", 64'(dreq.valid), 64'd1);
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        dresp = '0;
        check("fl_no_valid", 64'(out_valid), 64'd0);
        check("fl_ready_back", 64'(in_ready), 64'd1);
        check("fl_req_done", 64'(dreq.valid), 64'd0);
        tick();
        check("fl_no_valid2", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-BUS
        in_valid = 1'b1;
        in_data  = mk(64'h4000, '0, 1'b1, 1'b0, F3_LD, 5'd2);
        tick();
        in_valid = 1'b0;
        check("rbus_req", 64'(dreq.valid), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rbus_req_drop", 64'(dreq.valid), 64'd0);
        check("rbus_out_valid", 64'(out_valid), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        check("rbus_in_ready", 64'(in_ready), 64'd1);
        check("rbus_idle_req", 64'(dreq.valid), 64'd0);
        in_valid = 1'b1;
        in_data  = mk(64'h55, '0, 1'b0, 1'b0, 3'b000, 5'd1);
        tick();
        in_valid = 1'b0;
        check("rbus_alu_valid", 64'(out_valid), 64'd1);
        check("rbus_alu_aluout", out_data.aluout, 64'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
